seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 Parameter NDIG, default 4: number of multiplexed digits assembled into one output word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 seg_n  input  7  active-low segment lines; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-006 dig_sel  input  NDIG  digit strobe; bit i high selects digit i; valid only when exactly one-hot.
REQ-007 out_valid  output  1  assembled word available.
REQ-008 out_ready  input  1  consumer accepts word.
REQ-009 out_value  output  4*NDIG  decoded nibbles; digit i in bits [4i+3:4i].
REQ-010 digit_err  output  NDIG  bit i set when digit i carried an undecodable pattern.
REQ-011 out_err  output  1  OR-reduction of digit_err.

Function
REQ-012 The block SHALL register the pair (seg_n, dig_sel) every cycle and SHALL compare each new pair with the previously registered pair.
REQ-013 The stability counter SHALL clear to 0 on a mismatch or when dig_sel is not one-hot, SHALL increment on a match, and SHALL saturate at STABLE_CYCLES-1.
REQ-014 A capture SHALL occur exactly once per stable run: on the cycle the counter transitions to STABLE_CYCLES-1 with dig_sel one-hot.
REQ-015 Decode (active-high segments = ~seg_n, g..a): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
REQ-016 Any other pattern SHALL decode to nibble 0 with the digit's error bit set.
REQ-017 On a capture, the block SHALL write the nibble and error bit into the collection slot for the selected digit and set that slot's captured flag; recapturing an already-captured digit SHALL overwrite it (latest wins).
REQ-018 Output state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 EMPTY->FULL SHALL occur on the cycle after all NDIG captured flags are set; in that same edge the block loads the collection slots into out_value/digit_err and clears all captured flags.
REQ-020 FULL->EMPTY SHALL occur on an edge where out_valid && out_ready.
REQ-021 If all flags are set on a FULL && out_ready edge, the block SHALL reload directly and stay FULL (back-to-back words, no bubble).
REQ-022 While FULL and not draining, out_value, digit_err and out_err SHALL remain stable; collection SHALL continue, and complete flags SHALL hold until the output can load.
REQ-023 A capture on the same edge as a load SHALL land in the next word (its flag set after the clear).
REQ-024 Latency: a digit held constant from cycle t is captured at edge t+STABLE_CYCLES-1; the word appears at most one cycle after its last capture.
REQ-025 out_err SHALL be combinational from the registered digit_err.

Reset
REQ-026 While rst is high at an edge: out_valid=0, out_value=0, digit_err=0, counter=0, captured flags=0, collection slots=0, registered seg_n=7'h7F, registered dig_sel=0, state EMPTY.
REQ-027 Reset mid-collection or while FULL SHALL discard all partial and pending data with no word emitted.
REQ-028 Stimulus while rst is high SHALL NOT cause a capture after rst deasserts unless a fresh stable run of STABLE_CYCLES samples follows deassertion.

Verification
REQ-029 Hold seg_n=7'h40 with dig_sel=0001 for 4 cycles, then 7'h79/0010, 7'h24/0100, 7'h30/1000 (each 4 cycles), out_ready=1 -> one word, out_value=16'h3210, out_err=0.
REQ-030 Digit 2 gets seg_n=7'h00 (all segments lit, not 8 pattern is 7F... i.e. pattern 7F->8 valid); use seg_n=7'h7E instead -> digit_err=4'b0100, nibble 2=0, out_err=1.
REQ-031 Pattern toggles every 3 cycles with STABLE_CYCLES=4 -> no capture, out_valid stays 0; dig_sel=0011 held for 10 cycles -> no capture.
REQ-032 out_ready=0 after first word, second full digit set delivered -> first word held stable; on out_ready=1 edge, second word appears next cycle with no EMPTY gap.
REQ-033 rst pulsed for 1 cycle after 3 of 4 digits captured -> no word; then 4 fresh digits -> exactly one word with only the new values.
REQ-034 Digit 0 recaptured (5 then 7) before the set completes -> nibble 0 of the word = 7.

Source files
------------

// File: rtl/seg7_reader.sv
// seg7_reader: samples a multiplexed, active-low 7-segment display bus and
// assembles the decoded digits into one output word.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous, active-high reset
//   seg_n      - active-low segment lines, bit0=a .. bit6=g
//   dig_sel    - digit strobe; bit i selects digit i, valid only when one-hot
//   out_valid  - an assembled word is held on out_value/digit_err
//   out_ready  - consumer accepts the current word
//   out_value  - decoded nibbles, digit i in bits [4i+3:4i]
//   digit_err  - bit i set when digit i carried an undecodable pattern
//   out_err    - OR of digit_err (combinational from the registered bits)
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NDIG          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     dig_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_value,
    output logic [NDIG-1:0]     digit_err,
    output logic                out_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Sampled bus and stability tracking
    logic [6:0]        r_seg_n;
    logic [NDIG-1:0]   r_dig_sel;
    logic [CNT_W-1:0]  r_cnt;

    // Collection slots for the word being assembled
    logic [4*NDIG-1:0] r_slot_val;
    logic [NDIG-1:0]   r_slot_err;
    logic [NDIG-1:0]   r_flags;

    // Output side
    state_t            r_state;
    logic              r_out_valid;
    logic [4*NDIG-1:0] r_out_value;
    logic [NDIG-1:0]   r_digit_err;

    logic              w_onehot;
    logic              w_match;
    logic              w_capture;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [NDIG-1:0]   w_set;
    logic              w_all;
    logic              w_load;
    state_t            w_state_next;
    logic [3:0]        w_nib;
    logic              w_bad;

    assign w_onehot = $onehot(dig_sel);
    assign w_match  = (seg_n == r_seg_n) && (dig_sel == r_dig_sel);

    // Stability counter: clears on any change or non-one-hot strobe, saturates
    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_onehot || !w_match) begin
            w_cnt_next = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Fires only on the step into CNT_MAX, so a long stable run captures once
    assign w_capture = w_onehot && w_match && (r_cnt == CNT_PRE);
    assign w_set     = w_capture ? dig_sel : '0;
    assign w_all     = &r_flags;

    // Segment decode; anything outside the hex glyph set is an error
    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (~seg_n)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_bad = 1'b1;
        endcase
    end

    // Input sampling and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_n   <= 7'h7F;
            r_dig_sel <= '0;
            r_cnt     <= '0;
        end else begin
            r_seg_n   <= seg_n;
            r_dig_sel <= dig_sel;
            r_cnt     <= w_cnt_next;
        end
    end

    // Collection slots; a capture on a load edge sets its flag after the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_val <= '0;
            r_slot_err <= '0;
            r_flags    <= '0;
        end else begin
            r_flags <= (w_load ? '0 : r_flags) | w_set;
            for (int i = 0; i < int'(NDIG); i++) begin
                if (w_set[i]) begin
                    r_slot_val[4*i +: 4] <= w_nib;
                    r_slot_err[i]        <= w_bad;
                end
            end
        end
    end

    // Output FSM next-state; load whenever a complete set can be accepted
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_all) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (w_all) begin
                        w_load       = 1'b1;
                        w_state_next = ST_FULL;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Output FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output word registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_digit_err <= '0;
        end else begin
            r_out_valid <= (w_state_next == ST_FULL);
            if (w_load) begin
                r_out_value <= r_slot_val;
                r_digit_err <= r_slot_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign digit_err = r_digit_err;
    assign out_err   = |r_digit_err;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed, table-driven bench for seg7_reader with
// STABLE_CYCLES=4 and NDIG=4. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_seg7_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_value;
    logic [3:0]  digit_err;
    logic        out_err;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(4), .NDIG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .digit_err (digit_err),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [15:0]     exp_val;
        logic [3:0]      exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Hold one digit on the bus for n clock edges (entered and left on a negedge)
    task automatic send_digit(input logic [6:0] s, input int d, input int n);
        seg_n   = s;
        dig_sel = 4'(1 << d);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [3:0][6:0] s);
        for (int d = 0; d < 4; d++) send_digit(s[d], d, 4);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Patterns are seg_n (active-low); digit 0 is the first entry of the table row
        vecs[0] = '{seg: {7'h30, 7'h24, 7'h79, 7'h40}, exp_val: 16'h3210, exp_err: 4'b0000};
        vecs[1] = '{seg: {7'h30, 7'h7E, 7'h79, 7'h40}, exp_val: 16'h3010, exp_err: 4'b0100};
        vecs[2] = '{seg: {7'h78, 7'h02, 7'h12, 7'h19}, exp_val: 16'h7654, exp_err: 4'b0000};
        vecs[3] = '{seg: {7'h03, 7'h08, 7'h10, 7'h00}, exp_val: 16'hBA98, exp_err: 4'b0000};
        vecs[4] = '{seg: {7'h0E, 7'h06, 7'h21, 7'h46}, exp_val: 16'hFEDC, exp_err: 4'b0000};
        vecs[5] = '{seg: {7'h79, 7'h40, 7'h79, 7'h7F}, exp_val: 16'h1010, exp_err: 4'b0001};

        rst = 1'b1; seg_n = 7'h7F; dig_sel = 4'b0000; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_value", out_value, 16'h0);
        check("rst_derr",  16'(digit_err), 16'h0);
        check("rst_oerr",  16'(out_err), 16'h0);
        rst = 1'b0;

        // Table: one word per row, exact latency and contents checked
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].seg);
            check($sformatf("v%0d_not_yet", v), 16'(out_valid), 16'h0);
            @(negedge clk);
            check($sformatf("v%0d_valid", v), 16'(out_valid), 16'h1);
            check($sformatf("v%0d_value", v), out_value, vecs[v].exp_val);
            check($sformatf("v%0d_derr", v),  16'(digit_err), 16'(vecs[v].exp_err));
            check($sformatf("v%0d_oerr", v),  16'(out_err), 16'(|vecs[v].exp_err));
            drain();
            check($sformatf("v%0d_drained", v), 16'(out_valid), 16'h0);
        end

        // Unstable pattern and multi-hot strobe must not capture digit 0
        for (int k = 0; k < 4; k++) send_digit((k % 2) ? 7'h40 : 7'h78, 0, 3);
        seg_n = 7'h40; dig_sel = 4'b0011;
        repeat (10) @(negedge clk);
        send_digit(7'h79, 1, 4);
        send_digit(7'h24, 2, 4);
        send_digit(7'h30, 3, 4);
        repeat (3) @(negedge clk);
        check("nocap_valid", 16'(out_valid), 16'h0);
        send_digit(7'h12, 0, 4);
        @(negedge clk);
        check("nocap_word_valid", 16'(out_valid), 16'h1);
        check("nocap_word_value", out_value, 16'h3215);
        drain();

        // Back-pressure: first word held while second completes, then reload without a gap
        send_word(vecs[0].seg);
        @(negedge clk);
        check("bp_first_valid", 16'(out_valid), 16'h1);
        check("bp_first_value", out_value, 16'h3210);
        send_word(vecs[2].seg);
        repeat (2) @(negedge clk);
        check("bp_hold_valid", 16'(out_valid), 16'h1);
        check("bp_hold_value", out_value, 16'h3210);
        check("bp_hold_oerr",  16'(out_err), 16'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_second_valid", 16'(out_valid), 16'h1);
        check("bp_second_value", out_value, 16'h7654);
        drain();
        check("bp_drained", 16'(out_valid), 16'h0);

        // Reset while FULL discards the word
        send_word(vecs[1].seg);
        @(negedge clk);
        check("rf_valid", 16'(out_valid), 16'h1);
        pulse_rst();
        check("rf_after_valid", 16'(out_valid), 16'h0);
        check("rf_after_value", out_value, 16'h0);
        check("rf_after_oerr",  16'(out_err), 16'h0);

        // Reset mid-collection: old partial flags must be gone
        send_digit(7'h40, 0, 4);
        send_digit(7'h79, 1, 4);
        send_digit(7'h24, 2, 4);
        pulse_rst();
        check("rm_valid", 16'(out_valid), 16'h0);
        send_digit(7'h02, 3, 4);
        repeat (3) @(negedge clk);
        check("rm_partial_valid", 16'(out_valid), 16'h0);
        send_digit(7'h10, 0, 4);
        send_digit(7'h00, 1, 4);
        send_digit(7'h78, 2, 4);
        @(negedge clk);
        check("rm_word_valid", 16'(out_valid), 16'h1);
        check("rm_word_value", out_value, 16'h6789);
        drain();
        repeat (6) @(negedge clk);
        check("rm_single_word", 16'(out_valid), 16'h0);

        // Recapture of digit 0: latest value wins
        send_digit(7'h12, 0, 4);
        send_digit(7'h78, 0, 4);
        send_digit(7'h10, 1, 4);
        send_digit(7'h00, 2, 4);
        send_digit(7'h08, 3, 4);
        @(negedge clk);
        check("rc_valid", 16'(out_valid), 16'h1);
        check("rc_value", out_value, 16'hA897);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
